// File: rtl/u409_cia_cycle.sv
// CIA bus-cycle sequencer: derives the C7M/10 E clock and frames CPU accesses
// to the CIA space so the access window lines up with a full ECLK-high phase.
module u409_cia_cycle (
    input  logic CLK40,
    input  logic RESET,
    input  logic C7M_RISE,
    input  logic TS_n,
    input  logic CIA_SPACE,
    output logic ECLK,
    output logic CIA_ENABLE,
    output logic TA_n,
    output logic CIA_BUSY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2,
        TERM   = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] ecnt;
    logic [3:0] ecnt_next;
    logic       eclk_next;

    // Out-of-range counts collapse to 0 so a corrupted counter recovers in one strobe.
    always_comb begin
        ecnt_next = ecnt;
        if (C7M_RISE) begin
            ecnt_next = (ecnt >= 4'd9) ? 4'd0 : ecnt + 4'd1;
        end
        eclk_next = (ecnt_next >= 4'd6) && (ecnt_next <= 4'd9);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!TS_n && CIA_SPACE)           state_next = SYNC;
            SYNC:    if (C7M_RISE && ecnt == 4'd2)     state_next = ACTIVE;
            ACTIVE:  if (C7M_RISE && ecnt == 4'd9)     state_next = TERM;
            TERM:                                      state_next = IDLE;
            default:                                   state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they track the state exactly.
    always_ff @(posedge CLK40) begin
        if (RESET) begin
            ecnt       <= 4'd0;
            state      <= IDLE;
            ECLK       <= 1'b0;
            CIA_ENABLE <= 1'b0;
            TA_n       <= 1'b1;
            CIA_BUSY   <= 1'b0;
        end else begin
            ecnt       <= ecnt_next;
            state      <= state_next;
            ECLK       <= eclk_next;
            CIA_ENABLE <= (state_next == ACTIVE);
            TA_n       <= (state_next != TERM);
            CIA_BUSY   <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_u409_cia_cycle.sv
// Directed bench for u409_cia_cycle: a vector table for the basic access plus
// hand-written sequences for alignment, ignored requests, reset and free run.
module tb_u409_cia_cycle;

    logic clk = 1'b0;
    logic rst, rise, ts_n, space;
    logic eclk, en, ta_n, busy;

    int checks = 0;
    int failures = 0;
    int ecnt_m = 0;

    always #5 clk = ~clk;

    u409_cia_cycle dut (
        .CLK40     (clk),
        .RESET     (rst),
        .C7M_RISE  (rise),
        .TS_n      (ts_n),
        .CIA_SPACE (space),
        .ECLK      (eclk),
        .CIA_ENABLE(en),
        .TA_n      (ta_n),
        .CIA_BUSY  (busy)
    );

    typedef struct {
        logic r, ts, sp;
        logic e, en, ta, busy;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One CLK40 cycle: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic t, input logic s, input logic rs = 1'b0);
        @(negedge clk);
        rise = r; ts_n = t; space = s; rst = rs;
        @(posedge clk);
        #1;
        if (rs) ecnt_m = 0;
        else if (r) ecnt_m = (ecnt_m == 9) ? 0 : ecnt_m + 1;
    endtask

    task automatic strobe_to(input int target);
        for (int i = 0; i < 12 && ecnt_m != target; i++) step(1, 1, 0);
        chk("strobe_to", ecnt_m, target);
    endtask

    // Strobe until the sequencer returns idle; report TA pulses seen.
    task automatic drain(input string name, output int tas);
        int done;
        tas = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            step(1, 1, 0);
            if (ta_n === 1'b0) tas++;
            if (busy === 1'b0) done = 1;
        end
        chk({name, "_idle"}, done, 1);
    endtask

    initial begin
        int tas, first, fl;
        int hi, lo;
        rst = 1'b1; rise = 1'b0; ts_n = 1'b1; space = 1'b0;

        // Reset holds outputs even with strobes and requests present
        step(1, 0, 1, 1);
        step(1, 0, 1, 1);
        chk("rst_eclk", eclk, 0);
        chk("rst_en", en, 0);
        chk("rst_ta", ta_n, 1);
        chk("rst_busy", busy, 0);

        // Basic access starting at ECNT=0
        tbl[0]  = '{0, 0, 1, 0, 0, 1, 1};
        tbl[1]  = '{1, 1, 0, 0, 0, 1, 1};
        tbl[2]  = '{1, 1, 0, 0, 0, 1, 1};
        tbl[3]  = '{1, 1, 0, 0, 1, 1, 1};
        tbl[4]  = '{1, 1, 0, 0, 1, 1, 1};
        tbl[5]  = '{1, 1, 0, 0, 1, 1, 1};
        tbl[6]  = '{1, 1, 0, 1, 1, 1, 1};
        tbl[7]  = '{1, 1, 0, 1, 1, 1, 1};
        tbl[8]  = '{1, 1, 0, 1, 1, 1, 1};
        tbl[9]  = '{1, 1, 0, 1, 1, 1, 1};
        tbl[10] = '{1, 1, 0, 0, 0, 0, 1};
        tbl[11] = '{0, 1, 0, 0, 0, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, tbl[i].ts, tbl[i].sp);
            chk($sformatf("vec%0d_eclk", i), eclk, tbl[i].e);
            chk($sformatf("vec%0d_en", i), en, tbl[i].en);
            chk($sformatf("vec%0d_ta", i), ta_n, tbl[i].ta);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
        end

        // Request at ECNT=5 must wait for the next 2->3 transition
        strobe_to(5);
        step(0, 0, 1);
        chk("late_busy", busy, 1);
        first = -1; fl = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1, 1, 0);
            if (en === 1'b1 && first < 0) begin first = i; fl = ecnt_m; end
        end
        chk("late_en_strobe", first, 8);
        chk("late_en_ecnt", fl, 3);
        drain("late", tas);
        chk("late_ta_count", tas, 1);

        // Request on the ECNT 2->3 strobe edge waits one full E period
        strobe_to(2);
        step(1, 0, 1);
        chk("edge_busy", busy, 1);
        chk("edge_en", en, 0);
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            step(1, 1, 0);
            if (en === 1'b1 && first < 0) first = i;
        end
        chk("edge_en_strobe", first, 10);
        // Second request during ACTIVE is dropped
        step(0, 0, 1);
        chk("dup_en", en, 1);
        drain("dup", tas);
        chk("dup_ta_count", tas, 1);
        tas = 0;
        for (int i = 0; i < 15; i++) begin
            step(1, 1, 0);
            if (busy !== 1'b0 || ta_n !== 1'b1) tas++;
        end
        chk("dup_no_restart", tas, 0);

        // Reset mid-access at ECNT=7
        step(0, 0, 1);
        for (int i = 0; i < 25 && !(en === 1'b1 && ecnt_m == 7); i++) step(1, 1, 0);
        chk("mid_active_at7", (en === 1'b1 && ecnt_m == 7) ? 1 : 0, 1);
        step(1, 1, 0, 1);
        chk("mid_rst_en", en, 0);
        chk("mid_rst_ta", ta_n, 1);
        chk("mid_rst_eclk", eclk, 0);
        chk("mid_rst_busy", busy, 0);
        first = -1; tas = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1, 1, 0);
            if (eclk === 1'b1 && first < 0) first = i;
            if (ta_n === 1'b0 || busy === 1'b1) tas++;
        end
        chk("mid_eclk_first_high", first, 6);
        chk("mid_no_ta", tas, 0);

        // Free run: 40 strobes at half rate, ECLK 6 low / 4 high
        step(1, 1, 0, 1);
        hi = 0; lo = 0; fl = 0;
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 0);
            if (eclk === 1'b1) hi++; else lo++;
            if (eclk !== ((ecnt_m >= 6) ? 1'b1 : 1'b0)) fl++;
            step(0, 1, 0);
            if (eclk !== ((ecnt_m >= 6) ? 1'b1 : 1'b0)) fl++;
        end
        chk("free_high", hi, 16);
        chk("free_low", lo, 24);
        chk("free_phase_err", fl, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/u409_cia_cycle.md
U409_CIA_CYCLE -- requirements
Module: U409_CIA_CYCLE

Interface
REQ-001 CLK40  in  1  system clock; all state changes on its rising edge.
REQ-002 RESET  in  1  synchronous, active-high reset.
REQ-003 C7M_RISE  in  1  one-CLK40-cycle strobe marking each 7 MHz rising edge.
REQ-004 TS_n  in  1  CPU transfer start, active low, one CLK40 cycle wide.
REQ-005 CIA_SPACE  in  1  address-decode qualifier: current access targets the CIA space.
REQ-006 ECLK  out  1  E clock to the CIAs, registered.
REQ-007 CIA_ENABLE  out  1  CIA access window, registered; consumed by the CIA chip-select decode.
REQ-008 TA_n  out  1  transfer acknowledge for the CIA access, active low, registered.
REQ-009 CIA_BUSY  out  1  high whenever the state machine is not IDLE.

Function
REQ-010 A 4-bit counter ECNT SHALL advance by 1 on each CLK40 edge where C7M_RISE=1, and hold otherwise.
REQ-011 ECNT SHALL wrap from 9 to 0; values 10-15 are unreachable, and if ever present SHALL go to 0 on the next C7M_RISE.
REQ-012 ECLK SHALL be 1 exactly while ECNT is in 6..9 (6 low, 4 high phases = C7M/10).
REQ-013 The state machine SHALL have the states IDLE, SYNC, ACTIVE and TERM.
REQ-014 IDLE->SYNC when TS_n=0 and CIA_SPACE=1 on the same edge; TS_n=0 with CIA_SPACE=0 SHALL be ignored.
REQ-015 SYNC->ACTIVE on the edge where C7M_RISE=1 and ECNT=2 (ECNT becomes 3), giving three 7 MHz phases of setup before ECLK rises.
REQ-016 A request accepted while ECNT>=3 SHALL wait in SYNC for the next ECNT 2->3 transition; it SHALL NOT join a partially elapsed window.
REQ-017 A request accepted while ECNT=2 with C7M_RISE asserted on the same edge SHALL enter SYNC only; ACTIVE follows on the next qualifying transition (next E period).
REQ-018 ACTIVE->TERM on the edge where C7M_RISE=1 and ECNT=9 (ECLK falling).
REQ-019 TERM->IDLE unconditionally after one CLK40 cycle.
REQ-020 CIA_ENABLE SHALL be 1 exactly while the state is ACTIVE.
REQ-021 TA_n SHALL be 0 for exactly one CLK40 cycle, while the state is TERM; it SHALL be 1 otherwise.
REQ-022 TS_n=0 in SYNC, ACTIVE or TERM SHALL be ignored; no request is queued.
REQ-023 Latency from TS_n sample to TA_n low SHALL be between 7 and 17 C7M periods (plus at most 1 CLK40), depending on ECNT at acceptance.
REQ-024 ECNT and ECLK SHALL run continuously, independent of the state machine.

Reset
REQ-025 While RESET=1: ECNT=0, state=IDLE, ECLK=0, CIA_ENABLE=0, TA_n=1, CIA_BUSY=0.
REQ-026 RESET asserted mid-access (SYNC/ACTIVE/TERM) SHALL abandon the access with no TA_n pulse; outputs take reset values on the next edge.
REQ-027 After RESET deasserts, the first C7M_RISE SHALL move ECNT to 1; requests are accepted from the first non-reset edge.

Verification
REQ-028 Free run: 40 C7M_RISE strobes after reset -> ECLK low 6 / high 4 strobes, period 10, ECNT never exceeds 9.
REQ-029 TS_n=0, CIA_SPACE=1 at ECNT=0 -> CIA_ENABLE rises at ECNT 2->3; TA_n low one cycle right after ECNT 9->0; CIA_BUSY falls next cycle.
REQ-030 Request at ECNT=5 -> no CIA_ENABLE in current period; window opens at the next 2->3 transition; exactly one TA_n pulse.
REQ-031 TS_n=0 with CIA_SPACE=0, and a second TS_n=0/CIA_SPACE=1 during ACTIVE -> neither starts a cycle; one TA_n total.
REQ-032 RESET=1 for one cycle while ACTIVE at ECNT=7 -> CIA_ENABLE=0, TA_n stays 1, ECNT=0, ECLK=0 on the next edge.
REQ-033 Request with ECNT=2 and C7M_RISE=1 on the same edge -> SYNC only; ACTIVE entered one E period later (REQ-017).
